// File: rtl/mux_striping_nlane_pkg.sv
// -----------------------------------------------------------------------------
// mux_striping_nlane_pkg
//   Shared definitions for the N-lane un-striper.
//   - Width codes: a code c selects n = 2**c active lanes (x1, x2, x4, x8).
//   - FSM state encoding for the phase controller.
// -----------------------------------------------------------------------------
package mux_striping_nlane_pkg;

  // Link width codes carried on active_lanes.
  localparam int WC_X1 = 0;
  localparam int WC_X2 = 1;
  localparam int WC_X4 = 2;
  localparam int WC_X8 = 3;

  // IDLE waits for a lane-0 valid word to open a frame.
  // RUN walks the captured bank one slot per clock.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/mux_striping_nlane_phase_ctrl.sv
// -----------------------------------------------------------------------------
// mux_striping_nlane_phase_ctrl
//   Frame sequencer for the un-striper: FSM, phase counter, link-width latch
//   and the sticky configuration error.
//
//   Ports
//     clk_4f, reset_L  clock, synchronous active-low reset
//     active_lanes     width code (n = 2**code)
//     lane_valid       per-lane valid, used to open/close frames
//     capture_o        this edge loads a new lane bank
//     act_mask_o       active-lane mask that applies to the bank loaded now
//     phase_o          slot index p of the word emitted on this edge
//     state_o          FSM state (IDLE/RUN)
//     cfg_error_o      sticky: a width code asked for more lanes than exist
// -----------------------------------------------------------------------------
module mux_striping_nlane_phase_ctrl
  import mux_striping_nlane_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES) + 1,
  localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic [CW-1:0]    active_lanes,
  input  logic [LANES-1:0] lane_valid,
  output logic             capture_o,
  output logic [LANES-1:0] act_mask_o,
  output logic [PW-1:0]    phase_o,
  output fsm_state_e       state_o,
  output logic             cfg_error_o
);

  localparam logic [CW-1:0] LG_MAX = CW'($clog2(LANES));

  fsm_state_e    state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] lg_q, lg_d;      // log2 of the latched lane count
  logic [CW-1:0] lg_new;          // log2 of the lane count offered this edge
  logic          cfg_error_q, cfg_error_d;
  logic          illegal;
  logic          last_slot;
  logic          any_act;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    lg_d        = lg_q;
    cfg_error_d = cfg_error_q;
    capture_o   = 1'b0;

    // An oversize width request falls back to every physical lane.
    illegal = (active_lanes > LG_MAX);
    lg_new  = illegal ? LG_MAX : active_lanes;
    for (int k = 0; k < LANES; k++) begin
      act_mask_o[k] = (32'(k) < (32'd1 << lg_new));
    end
    any_act   = |(lane_valid & act_mask_o);
    last_slot = (32'(p_q) == ((32'd1 << lg_q) - 32'd1));

    case (state_q)
      ST_IDLE: begin
        // Width is tracked on every idle edge so a frame opens at the
        // width presented alongside its first bank.
        lg_d        = lg_new;
        cfg_error_d = cfg_error_q | illegal;
        if (lane_valid[0]) begin
          capture_o = 1'b1;
          p_d       = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_slot) begin
          // Last slot of the frame: reload the bank on the same edge so
          // consecutive frames run without a gap. A bank with no active
          // valid lane ends the stream; its last word still goes out now.
          capture_o   = 1'b1;
          lg_d        = lg_new;
          cfg_error_d = cfg_error_q | illegal;
          p_d         = '0;
          if (!any_act) begin
            state_d = ST_IDLE;
          end
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      lg_q        <= '0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      lg_q        <= lg_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign phase_o     = p_q;
  assign state_o     = state_q;
  assign cfg_error_o = cfg_error_q;

endmodule

// File: rtl/mux_striping_nlane.sv
// -----------------------------------------------------------------------------
// mux_striping_nlane
//   Lane un-striper: merges up to LANES parallel WIDTH-bit lanes into one
//   word stream on clk_4f, with a runtime link width of 2**active_lanes.
//
//   Valid semantics (no backpressure): a lane word is taken only on a
//   capture edge and only if its lane_valid bit is set; data_output is
//   meaningful only while valid_out is high. The source holds lanes stable
//   up to each capture edge; downstream must accept every valid word.
//
//   Ports
//     clk_4f        output word-rate clock
//     reset_L       synchronous active-low reset
//     active_lanes  width code (0=x1, 1=x2, 2=x4, ...)
//     lane_data     packed lanes, lane k = [k*WIDTH +: WIDTH]
//     lane_valid    per-lane valid
//     data_output   merged word (registered)
//     valid_out     data_output qualifier (registered)
//     frame_start   high while the lane-0 word of a frame is on data_output
//     lane_error    sticky: active lanes disagreed on valid at a capture
//     cfg_error     sticky: width code asked for more lanes than LANES
// -----------------------------------------------------------------------------
module mux_striping_nlane
  import mux_striping_nlane_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(LANES) + 1
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  input  logic [CW-1:0]          active_lanes,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [LANES-1:0]       lane_valid,
  output logic [WIDTH-1:0]       data_output,
  output logic                   valid_out,
  output logic                   frame_start,
  output logic                   lane_error,
  output logic                   cfg_error
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic             capture;
  logic [LANES-1:0] act_mask;
  logic [PW-1:0]    phase;
  fsm_state_e       state;

  logic [WIDTH-1:0] bank_q [LANES];
  logic [LANES-1:0] bank_v_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             frame_start_q;
  logic             lane_error_q;
  logic             lane_hole;

  mux_striping_nlane_phase_ctrl #(
    .LANES (LANES)
  ) u_phase_ctrl (
    .clk_4f       (clk_4f),
    .reset_L      (reset_L),
    .active_lanes (active_lanes),
    .lane_valid   (lane_valid),
    .capture_o    (capture),
    .act_mask_o   (act_mask),
    .phase_o      (phase),
    .state_o      (state),
    .cfg_error_o  (cfg_error)
  );

  // A hole is a capture where some, but not all, active lanes are valid.
  assign lane_hole = capture
                   && (|(lane_valid & act_mask))
                   && ((lane_valid & act_mask) != act_mask);

  // Inactive lanes are stored with valid forced low; they are never
  // addressed by the phase counter anyway.
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      for (int k = 0; k < LANES; k++) begin
        bank_q[k] <= '0;
      end
      bank_v_q <= '0;
    end else if (capture) begin
      for (int k = 0; k < LANES; k++) begin
        bank_q[k] <= lane_data[k*WIDTH +: WIDTH];
      end
      bank_v_q <= lane_valid & act_mask;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      lane_error_q  <= 1'b0;
    end else begin
      if (state == ST_RUN) begin
        data_q        <= bank_q[phase];
        valid_q       <= bank_v_q[phase];
        frame_start_q <= (phase == '0);
      end else begin
        valid_q       <= 1'b0;
        frame_start_q <= 1'b0;
      end
      if (lane_hole) begin
        lane_error_q <= 1'b1;
      end
    end
  end

  assign data_output = data_q;
  assign valid_out   = valid_q;
  assign frame_start = frame_start_q;
  assign lane_error  = lane_error_q;

endmodule

// File: tb/tb_mux_striping_nlane.sv
// -----------------------------------------------------------------------------
// tb_mux_striping_nlane
//   Bench for mux_striping_nlane (LANES=4, WIDTH=32). A slot-queue reference
//   model predicts the output of every edge; scenario tasks add directed
//   expectations built from constants.
// -----------------------------------------------------------------------------
module tb_mux_striping_nlane;
  import mux_striping_nlane_pkg::*;

  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(LANES) + 1;
  localparam int VW    = WIDTH + 4;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk_4f = 1'b0;
  logic                   reset_L = 1'b0;
  logic [CW-1:0]          active_lanes = '0;
  logic [LANES*WIDTH-1:0] lane_data = '0;
  logic [LANES-1:0]       lane_valid = '0;
  logic [WIDTH-1:0]       data_output;
  logic                   valid_out;
  logic                   frame_start;
  logic                   lane_error;
  logic                   cfg_error;

  int checks = 0;
  int errors = 0;

  always #5 clk_4f = ~clk_4f;

  mux_striping_nlane #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) dut (
    .clk_4f       (clk_4f),
    .reset_L      (reset_L),
    .active_lanes (active_lanes),
    .lane_data    (lane_data),
    .lane_valid   (lane_valid),
    .data_output  (data_output),
    .valid_out    (valid_out),
    .frame_start  (frame_start),
    .lane_error   (lane_error),
    .cfg_error    (cfg_error)
  );

  // ---------------- reference model ----------------
  // The model keeps the words still owed by the current frame in a queue.
  // Empty queue = idle. A new bank is taken when idle and lane 0 is valid,
  // or when the word leaving now is the last one owed.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             first;
  } slot_t;

  slot_t            m_q[$];
  logic [WIDTH-1:0] m_data = '0;
  logic             m_valid = 1'b0;
  logic             m_fs = 1'b0;
  logic             m_lerr = 1'b0;
  logic             m_cerr = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  function automatic void model_step(logic rst_l, logic [CW-1:0] code,
                                     logic [LANES*WIDTH-1:0] d, logic [LANES-1:0] v);
    bit               was_idle;
    bit               cap;
    int               n;
    logic [LANES-1:0] mask;
    logic [LANES-1:0] act;
    slot_t            s;
    if (!rst_l) begin
      m_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_fs    = 1'b0;
      m_lerr  = 1'b0;
      m_cerr  = 1'b0;
      return;
    end
    was_idle = (m_q.size() == 0);
    cap      = was_idle ? bit'(v[0]) : (m_q.size() == 1);
    if (was_idle) begin
      m_valid = 1'b0;
      m_fs    = 1'b0;
    end else begin
      s       = m_q.pop_front();
      m_data  = s.data;
      m_valid = s.valid;
      m_fs    = s.first;
    end
    if (was_idle || cap) begin
      n = 1 << code;
      if (n > LANES) begin
        n      = LANES;
        m_cerr = 1'b1;
      end
      if (cap) begin
        mask = '0;
        for (int k = 0; k < n; k++) mask[k] = 1'b1;
        act = v & mask;
        if (act != '0 && act != mask) m_lerr = 1'b1;
        if (act != '0) begin
          for (int k = 0; k < n; k++) begin
            m_q.push_back('{d[k*WIDTH +: WIDTH], act[k], (k == 0)});
          end
        end
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_fs, m_lerr, m_cerr, (m_valid ? m_data : {WIDTH{1'b0}})};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {valid_out, frame_start, lane_error, cfg_error,
            (valid_out ? data_output : {WIDTH{1'b0}})};
  endfunction

  // ---------------- driver ----------------
  function automatic logic [LANES*WIDTH-1:0] rand_lanes();
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = $urandom;
    return r;
  endfunction

  // Lane k carries base + k, e.g. base 0xA00 -> A00, A01, A02, A03.
  function automatic logic [LANES*WIDTH-1:0] frame_data(int base);
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    return r;
  endfunction

  // Drive inputs while the clock is low, let one edge happen, advance the
  // model with the same inputs, and return at the falling edge.
  task automatic cycle(input logic rst_l, input logic [CW-1:0] code,
                       input logic [LANES*WIDTH-1:0] d, input logic [LANES-1:0] v);
    reset_L      = rst_l;
    active_lanes = code;
    lane_data    = d;
    lane_valid   = v;
    @(posedge clk_4f);
    model_step(rst_l, code, d, v);
    @(negedge clk_4f);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, CW'($urandom_range(0, 3)), rand_lanes(), LANES'($urandom));
      checks++;
      if ({data_output, valid_out, frame_start, lane_error, cfg_error} !== '0) begin
        errors++;
        $display("FAIL reset c=%0d got d=%h v=%b fs=%b le=%b ce=%b want all 0",
                 c, data_output, valid_out, frame_start, lane_error, cfg_error);
      end
    end
  endtask

  task automatic test_x4_stream();
    int idx = 0;
    exp_q.delete();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++) exp_q.push_back(WIDTH'('hA00 + f * 'h100 + k));
    for (int c = 0; c < 18; c++) begin
      if (c < 12) cycle(1'b1, CW'(WC_X4), frame_data('hA00 + (c / 4) * 'h100), 4'hF);
      else        cycle(1'b1, CW'(WC_X4), rand_lanes(), 4'h0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL x4_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (idx >= exp_q.size() || data_output !== exp_q[idx] || c != idx + 1
            || frame_start !== (idx % 4 == 0)) begin
          errors++;
          $display("FAIL x4_stream c=%0d got d=%h fs=%b want word %0d at c=%0d", c,
                   data_output, frame_start, idx, idx + 1);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 12) begin
      errors++;
      $display("FAIL x4_count got %0d words want 12", idx);
    end
  endtask

  task automatic test_x2_x1();
    int               widx = 0;
    logic [WIDTH-1:0] want;
    logic [WIDTH-1:0] prev_d = '0;
    logic             prev_v = 1'b0;
    logic [LANES*WIDTH-1:0] d;
    logic [LANES-1:0]       v;
    // x2: lanes 0/1 alternate; lanes 2/3 carry noise that must be ignored.
    for (int c = 0; c < 12; c++) begin
      d = rand_lanes();
      d[0 +: WIDTH]     = 32'h11;
      d[WIDTH +: WIDTH] = 32'h22;
      v = {2'($urandom), (c < 8) ? 2'b11 : 2'b00};
      cycle(1'b1, CW'(WC_X2), d, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL x2_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (valid_out === 1'b1) begin
        want = (widx % 2 == 0) ? 32'h11 : 32'h22;
        checks++;
        if (data_output !== want) begin
          errors++;
          $display("FAIL x2_alt c=%0d got %h want %h", c, data_output, want);
        end
        widx++;
      end
    end
    checks++;
    if (widx != 8) begin
      errors++;
      $display("FAIL x2_count got %0d words want 8", widx);
    end
    // x1: lane 0 reappears one edge after it was sampled.
    for (int c = 0; c < 24; c++) begin
      d = rand_lanes();
      v = LANES'($urandom);
      if (c < 20) v[0] = ($urandom_range(0, 4) != 0);
      else        v[0] = 1'b0;
      cycle(1'b1, CW'(WC_X1), d, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL x1_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      checks++;
      if (valid_out !== prev_v || (prev_v && data_output !== prev_d)) begin
        errors++;
        $display("FAIL x1_delay c=%0d got v=%b d=%h want v=%b d=%h", c, valid_out,
                 data_output, prev_v, prev_d);
      end
      prev_d = d[0 +: WIDTH];
      prev_v = v[0];
    end
    checks++;
    if (lane_error !== 1'b0) begin
      errors++;
      $display("FAIL inactive_no_err got lane_error=%b want 0", lane_error);
    end
  endtask

  task automatic test_hole();
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, CW'(WC_X4), frame_data('hD00), (c < 4) ? 4'b1011 : 4'b0000);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hole_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (valid_out !== (c != 3) || (c != 3 && data_output !== WIDTH'('hD00 + c - 1))) begin
          errors++;
          $display("FAIL hole_slot c=%0d got v=%b d=%h want v=%b", c, valid_out,
                   data_output, (c != 3));
        end
      end
      checks++;
      if (lane_error !== 1'b1) begin
        errors++;
        $display("FAIL hole_sticky c=%0d got lane_error=%b want 1", c, lane_error);
      end
    end
  endtask

  task automatic test_width_change();
    logic [WIDTH-1:0] words[$];
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(WIDTH'('hE00 + k));
    for (int k = 0; k < 2; k++) exp_q.push_back(WIDTH'('hF00 + k));
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, (c < 2) ? CW'(WC_X4) : CW'(WC_X2),
            (c < 4) ? frame_data('hE00) : frame_data('hF00), (c < 6) ? 4'hF : 4'h0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wchg_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (valid_out === 1'b1) words.push_back(data_output);
    end
    checks++;
    if (words.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wchg_count got %0d words want %0d", words.size(), exp_q.size());
    end else begin
      foreach (words[i]) begin
        checks++;
        if (words[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wchg_word %0d got %h want %h", i, words[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal_reset();
    for (int c = 0; c < 11; c++) begin
      cycle((c != 7), CW'(WC_X8), (c < 4) ? frame_data('h500) : frame_data('h600),
            (c < 7) ? 4'hF : 4'h0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL illegal_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
      if (c == 0) begin
        checks++;
        if (cfg_error !== 1'b1) begin
          errors++;
          $display("FAIL cfg_error got %b want 1", cfg_error);
        end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (valid_out !== 1'b1 || data_output !== WIDTH'('h500 + c - 1)) begin
          errors++;
          $display("FAIL illegal_x4 c=%0d got v=%b d=%h want v=1 d=%h", c, valid_out,
                   data_output, WIDTH'('h500 + c - 1));
        end
      end
      if (c == 7) begin
        checks++;
        if ({data_output, valid_out, frame_start, lane_error, cfg_error} !== '0) begin
          errors++;
          $display("FAIL midframe_reset got d=%h v=%b fs=%b le=%b ce=%b want all 0",
                   data_output, valid_out, frame_start, lane_error, cfg_error);
        end
      end
      if (c > 7) begin
        checks++;
        if (valid_out !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_idle c=%0d got valid_out=%b want 0", c, valid_out);
        end
      end
    end
  endtask

  task automatic test_random();
    logic             rst_l;
    logic [CW-1:0]    code;
    logic [LANES-1:0] v;
    int               r;
    for (int c = 0; c < 600; c++) begin
      rst_l = ($urandom_range(0, 79) != 0);
      code  = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(3, 7)) : CW'($urandom_range(0, 2));
      r     = $urandom_range(0, 99);
      v     = (r < 70) ? 4'hF : (r < 85) ? LANES'($urandom) : 4'h0;
      cycle(rst_l, code, rand_lanes(), v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_x4_stream();
    test_x2_x1();
    test_hole();
    test_width_change();
    test_illegal_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
